ts4231_pulse_capture: RTL and testbench
=======================================

# ts4231_pulse_capture

Captures light pulses from one TS4231 sensor once the sensor configurator reports `configured`. It samples the sensor's E envelope and D data lines, timestamps each pulse, measures its width and counts D edges. Each measurement is delivered as one record over a valid/ready handshake to the downstream pulse processing logic. The block only reads E and D; it never drives them, because the configurator owns the output enables.

## Interface
Parameters:
- `TS_WIDTH`, 24: width of the free-running timestamp counter and of `pulse_ts`.
- `W_WIDTH`, 16: width of `pulse_width`; the value saturates at all-ones.
- `MIN_WIDTH`, 4: pulses shorter than this many cycles are rejected as glitches.

Ports:
- `clk` in 1: the single clock for the block.
- `rst` in 1: asynchronous, active-high reset.
- `configured` in 1: configurator done flag. Capture is enabled only while this is high.
- `e_in` in 1: raw envelope line, asynchronous, active low (low means light present).
- `d_in` in 1: raw data line, asynchronous.
- `pulse_valid` out 1: a record is available.
- `pulse_ready` in 1: the consumer accepts the record.
- `pulse_ts` out TS_WIDTH: timestamp of the pulse start.
- `pulse_width` out W_WIDTH: pulse length in clk cycles.
- `pulse_d_edges` out 8: number of D transitions during the pulse, saturating at 255.
- `drop_count` out 8: number of records lost because the output register was full, saturating at 255.

## Operation
- **Input conditioning:** E and D each pass through a 2-flop synchronizer. Edge detection runs on the synchronized values.
- **Timestamp counter:** `ts_cnt` is free-running, increments every cycle, wraps modulo 2^TS_WIDTH, and resets to 0.
- **State machine**, states DISABLED, WAIT_IDLE, ARMED, IN_PULSE:
  - DISABLED: entered whenever `configured`=0, from any state. Goes to WAIT_IDLE when `configured`=1.
  - WAIT_IDLE: waits for synchronized E=1 to avoid capturing a partial pulse. Then goes to ARMED.
  - ARMED: on a synchronized E falling edge, latch `start_ts`=ts_cnt, set `width_cnt`=1 and `d_edges`=0, go to IN_PULSE.
  - IN_PULSE: `width_cnt` increments each cycle and saturates at 2^W_WIDTH-1. Each synchronized D change increments `d_edges`, saturating at 255. On a synchronized E rising edge the state returns to ARMED, and the record is emitted if `width_cnt` ≥ MIN_WIDTH; otherwise it is silently discarded.
- **Output register:** one entry.
  - Emit when `pulse_valid`=0: load `pulse_ts`/`pulse_width`/`pulse_d_edges` and set `pulse_valid`.
  - Emit when `pulse_valid`=1 and `pulse_ready`=1 in the same cycle: load the new record and keep `pulse_valid`=1. No drop.
  - Emit when `pulse_valid`=1 and `pulse_ready`=0: keep the old record and increment `drop_count`, saturating.
  - Handshake: `pulse_valid` stays asserted with stable data until `pulse_ready`. The record transfers on a clk edge where both are high.
- **`configured` falls mid-pulse:** abort to DISABLED with no emit. A record already held in the output register is retained until it is accepted.
- **Timestamp wrap-around:** the timestamp is not corrected. The consumer computes differences modulo 2^TS_WIDTH.

## Timing
- **Reset values:** `pulse_valid`=0, `pulse_ts`=0, `pulse_width`=0, `pulse_d_edges`=0, `drop_count`=0, state DISABLED.
- **Synchronizer latency:** 2 cycles from the raw pin to the synchronized value. The third flop forms the previous-value register for edge detection. The same lag applies to both edges, so `pulse_width` equals the raw low time ±1 cycle.
- **Timestamp latch:** `start_ts` is latched in the cycle the synchronized falling edge is detected. This is a constant 2-cycle offset from the pin, which is not compensated.
- **Record latency:** `pulse_valid` rises 1 cycle after the cycle in which the synchronized rising edge is detected.
- **Back-to-back pulses:** a new falling edge may be detected the cycle after a rising edge. The minimum pulse period handled is 2 cycles plus MIN_WIDTH.

## Structure
- **Shared package (the lighthouse package):** the state enumeration and default widths (TS_WIDTH, W_WIDTH) live there.
- **Sub-module `sync_edge_detect`:** a single-bit 3-flop synchronizer with rise/fall/change pulse outputs. It is instantiated twice, for E and D.

## Test plan
- **Basic pulse:** `configured`=1, E held high 10 cycles, then E low for exactly 100 cycles with D toggling 6 times → one record: `pulse_width`=100±1, `pulse_d_edges`=6, `pulse_ts` = ts_cnt at pin fall + 2.
- **Glitch reject:** E low for 3 cycles with MIN_WIDTH=4 → no record, `drop_count`=0.
- **Backpressure:** `pulse_ready`=0 while 3 pulses of 20 cycles occur → first record held unchanged, `drop_count`=2. Then `pulse_ready`=1 → first record accepted, `pulse_valid`=0 next cycle.
- **Simultaneous accept and emit:** time `pulse_ready`=1 on the cycle a new record emits → new record loaded, `pulse_valid` stays 1, `drop_count` unchanged.
- **Partial pulse and disable:** E already low when `configured` rises → no capture until E goes high and a fresh fall occurs. `configured` dropped mid-pulse → no record.
- **Saturation, wrap and reset:** E low for 70000 cycles → `pulse_width`=0xFFFF. Timestamp crossing 0xFFFFFF → wraps to 0. `rst` asserted mid-pulse → all outputs return to their reset values immediately, asynchronously.

Source files
------------

// File: rtl/ts4231_pulse_capture_pkg.sv
// Shared lighthouse definitions: capture state encoding, default widths
// and the saturating counter helper used by the capture datapath.
package ts4231_pulse_capture_pkg;

  typedef enum logic [1:0] {
    ST_DISABLED  = 2'd0,
    ST_WAIT_IDLE = 2'd1,
    ST_ARMED     = 2'd2,
    ST_IN_PULSE  = 2'd3
  } cap_state_t;

  localparam int unsigned DEF_TS_WIDTH  = 24;
  localparam int unsigned DEF_W_WIDTH   = 16;
  localparam int unsigned DEF_MIN_WIDTH = 4;

  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    logic [7:0] result;
    if (value == 8'hFF) begin
      result = value;
    end else begin
      result = value + 8'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/ts4231_pulse_capture_sync_edge_detect.sv
// Single-bit 2-flop synchronizer with a third flop holding the previous
// synchronized value, producing rise/fall/change strobes.
module ts4231_pulse_capture_sync_edge_detect #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall,
  output logic change
);

  logic meta_r;
  logic sync_r;
  logic prev_r;

  // synchronizer chain plus previous-value register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_r <= RESET_VAL;
      sync_r <= RESET_VAL;
      prev_r <= RESET_VAL;
    end else begin
      meta_r <= din;
      sync_r <= meta_r;
      prev_r <= sync_r;
    end
  end

  assign sync   = sync_r;
  assign rise   = sync_r & ~prev_r;
  assign fall   = ~sync_r & prev_r;
  assign change = sync_r ^ prev_r;

endmodule

// File: rtl/ts4231_pulse_capture.sv
// TS4231 pulse capture: timestamps each envelope pulse, measures its width
// and D activity, and offers one record at a time over valid/ready.
module ts4231_pulse_capture
  import ts4231_pulse_capture_pkg::*;
#(
  parameter int unsigned TS_WIDTH  = DEF_TS_WIDTH,
  parameter int unsigned W_WIDTH   = DEF_W_WIDTH,
  parameter int unsigned MIN_WIDTH = DEF_MIN_WIDTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                configured,
  input  logic                e_in,
  input  logic                d_in,
  output logic                pulse_valid,
  input  logic                pulse_ready,
  output logic [TS_WIDTH-1:0] pulse_ts,
  output logic [W_WIDTH-1:0]  pulse_width,
  output logic [7:0]          pulse_d_edges,
  output logic [7:0]          drop_count
);

  localparam logic [TS_WIDTH-1:0] TS_ONE = {{(TS_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [W_WIDTH-1:0]  W_ONE  = {{(W_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [W_WIDTH-1:0]  W_MAX  = {W_WIDTH{1'b1}};
  localparam logic [W_WIDTH-1:0]  W_MIN  = W_WIDTH'(MIN_WIDTH);

  cap_state_t          state_r;
  cap_state_t          state_nxt_s;
  logic [TS_WIDTH-1:0] ts_cnt_r;
  logic [TS_WIDTH-1:0] start_ts_r;
  logic [W_WIDTH-1:0]  width_cnt_r;
  logic [7:0]          d_edges_r;
  logic                start_pulse_s;
  logic                emit_s;

  logic e_sync_s;
  logic e_rise_s;
  logic e_fall_s;
  logic e_change_unused;
  logic d_sync_unused;
  logic d_rise_unused;
  logic d_fall_unused;
  logic d_change_s;

  // E idles high (no light), so its synchronizer resets high to avoid a false fall
  ts4231_pulse_capture_sync_edge_detect #(.RESET_VAL(1'b1)) u_sync_e (
    .clk    (clk),
    .rst    (rst),
    .din    (e_in),
    .sync   (e_sync_s),
    .rise   (e_rise_s),
    .fall   (e_fall_s),
    .change (e_change_unused)
  );

  ts4231_pulse_capture_sync_edge_detect #(.RESET_VAL(1'b0)) u_sync_d (
    .clk    (clk),
    .rst    (rst),
    .din    (d_in),
    .sync   (d_sync_unused),
    .rise   (d_rise_unused),
    .fall   (d_fall_unused),
    .change (d_change_s)
  );

  // free-running timestamp, wraps naturally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts_cnt_r <= '0;
    end else begin
      ts_cnt_r <= ts_cnt_r + TS_ONE;
    end
  end

  // capture state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_DISABLED;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // next-state and pulse start/emit decode; losing configured aborts silently
  always_comb begin
    state_nxt_s   = state_r;
    start_pulse_s = 1'b0;
    emit_s        = 1'b0;
    if (!configured) begin
      state_nxt_s = ST_DISABLED;
    end else begin
      case (state_r)
        ST_DISABLED: begin
          state_nxt_s = ST_WAIT_IDLE;
        end
        ST_WAIT_IDLE: begin
          if (e_sync_s) begin
            state_nxt_s = ST_ARMED;
          end else begin
            state_nxt_s = ST_WAIT_IDLE;
          end
        end
        ST_ARMED: begin
          if (e_fall_s) begin
            state_nxt_s   = ST_IN_PULSE;
            start_pulse_s = 1'b1;
          end else begin
            state_nxt_s = ST_ARMED;
          end
        end
        ST_IN_PULSE: begin
          if (e_rise_s) begin
            state_nxt_s = ST_ARMED;
            emit_s      = (width_cnt_r >= W_MIN);
          end else begin
            state_nxt_s = ST_IN_PULSE;
          end
        end
        default: begin
          state_nxt_s = ST_DISABLED;
        end
      endcase
    end
  end

  // per-pulse measurement: start time, saturating width and D edge count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_ts_r  <= '0;
      width_cnt_r <= '0;
      d_edges_r   <= 8'd0;
    end else if (start_pulse_s) begin
      start_ts_r  <= ts_cnt_r;
      width_cnt_r <= W_ONE;
      d_edges_r   <= 8'd0;
    end else if (state_r == ST_IN_PULSE) begin
      if (width_cnt_r != W_MAX) begin
        width_cnt_r <= width_cnt_r + W_ONE;
      end else begin
        width_cnt_r <= width_cnt_r;
      end
      if (d_change_s) begin
        d_edges_r <= sat_inc8(d_edges_r);
      end else begin
        d_edges_r <= d_edges_r;
      end
    end else begin
      width_cnt_r <= width_cnt_r;
    end
  end

  // one-entry output register; a new record overwrites only a free or departing slot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pulse_valid   <= 1'b0;
      pulse_ts      <= '0;
      pulse_width   <= '0;
      pulse_d_edges <= 8'd0;
      drop_count    <= 8'd0;
    end else if (emit_s) begin
      if (!pulse_valid || pulse_ready) begin
        pulse_valid   <= 1'b1;
        pulse_ts      <= start_ts_r;
        pulse_width   <= width_cnt_r;
        pulse_d_edges <= d_edges_r;
      end else begin
        drop_count <= sat_inc8(drop_count);
      end
    end else if (pulse_valid && pulse_ready) begin
      pulse_valid <= 1'b0;
    end else begin
      pulse_valid <= pulse_valid;
    end
  end

endmodule

// File: tb/tb_ts4231_pulse_capture.sv
// Randomized and directed bench for ts4231_pulse_capture; expected records
// are derived from the pulses the bench itself drives on the raw pins.
module tb_ts4231_pulse_capture;

  localparam int TS_W  = 12;
  localparam int W_W   = 16;
  localparam int MIN_W = 4;

  typedef struct {
    logic [TS_W-1:0] ts;
    int              width;
    int              dedges;
  } rec_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            configured;
  logic            e_in;
  logic            d_in;
  logic            pulse_valid;
  logic            pulse_ready;
  logic [TS_W-1:0] pulse_ts;
  logic [W_W-1:0]  pulse_width;
  logic [7:0]      pulse_d_edges;
  logic [7:0]      drop_count;

  int checks = 0;
  int errors = 0;
  int exp_drop = 0;

  logic [TS_W-1:0] model_ts;
  rec_t            got_q[$];
  rec_t            exp_q[$];

  ts4231_pulse_capture #(.TS_WIDTH(TS_W), .W_WIDTH(W_W), .MIN_WIDTH(MIN_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .configured    (configured),
    .e_in          (e_in),
    .d_in          (d_in),
    .pulse_valid   (pulse_valid),
    .pulse_ready   (pulse_ready),
    .pulse_ts      (pulse_ts),
    .pulse_width   (pulse_width),
    .pulse_d_edges (pulse_d_edges),
    .drop_count    (drop_count)
  );

  always #5 clk = ~clk;

  // free-running timestamp as the consumer understands it: cycles since reset, modulo 2^TS_W
  always @(posedge clk or posedge rst) begin
    if (rst) model_ts <= '0;
    else     model_ts <= model_ts + 12'd1;
  end

  // transfers happen on the next rising edge when both valid and ready are high
  always @(negedge clk) begin
    if (!rst && pulse_valid && pulse_ready)
      got_q.push_back('{ts: pulse_ts, width: int'(pulse_width), dedges: int'(pulse_d_edges)});
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // E low for exactly 'low' clock edges, with 'tog' D toggles spread inside the pulse
  task automatic drive_pulse(input int low, input int tog,
                             output logic [TS_W-1:0] ts_exp, output int tog_done);
    int remaining;
    int slots;
    e_in = 1'b0;
    ts_exp = model_ts + 12'd2;
    remaining = (tog > low - 1) ? low - 1 : tog;
    tog_done = remaining;
    for (int c = 0; c < low; c++) begin
      @(posedge clk);
      #1;
      slots = low - 1 - c;
      if (slots > 0 && remaining > 0 && int'($urandom_range(slots - 1, 0)) < remaining) begin
        d_in = ~d_in;
        remaining--;
      end
    end
    e_in = 1'b1;
  endtask

  task automatic wait_valid(input int max, output int waited, output bit ok);
    ok = 1'b0;
    waited = 0;
    for (int i = 0; i <= max; i++) begin
      if (pulse_valid) begin
        ok = 1'b1;
        break;
      end
      if (i < max) begin
        step(1);
        waited++;
      end
    end
  endtask

  task automatic test_reset();
    checks++; if (pulse_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", pulse_valid); end
    checks++; if (pulse_ts !== 12'd0) begin errors++; $display("FAIL reset_ts: got %0d expected 0", pulse_ts); end
    checks++; if (pulse_width !== 16'd0) begin errors++; $display("FAIL reset_width: got %0d expected 0", pulse_width); end
    checks++; if (pulse_d_edges !== 8'd0) begin errors++; $display("FAIL reset_dedges: got %0d expected 0", pulse_d_edges); end
    checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL reset_drop: got %0d expected 0", drop_count); end
  endtask

  task automatic test_basic();
    logic [TS_W-1:0] ts_exp;
    int tog;
    int waited;
    bit ok;
    configured = 1'b1;
    pulse_ready = 1'b0;
    step(10);
    drive_pulse(100, 6, ts_exp, tog);
    wait_valid(10, waited, ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_valid: got 0 expected 1 within 10 cycles"); end
    checks++; if (waited != 3) begin errors++; $display("FAIL basic_latency: got %0d expected 3", waited); end
    checks++; if (pulse_ts !== ts_exp) begin errors++; $display("FAIL basic_ts: got %0d expected %0d", pulse_ts, ts_exp); end
    checks++; if (int'(pulse_width) < 99 || int'(pulse_width) > 101) begin errors++; $display("FAIL basic_width: got %0d expected 100+-1", pulse_width); end
    checks++; if (int'(pulse_d_edges) != tog) begin errors++; $display("FAIL basic_dedges: got %0d expected %0d", pulse_d_edges, tog); end
    step(5);
    checks++; if (pulse_ts !== ts_exp || pulse_valid !== 1'b1) begin errors++; $display("FAIL basic_hold: got ts %0d valid %0b expected ts %0d valid 1", pulse_ts, pulse_valid, ts_exp); end
    pulse_ready = 1'b1;
    step(1);
    pulse_ready = 1'b0;
    checks++; if (pulse_valid !== 1'b0) begin errors++; $display("FAIL basic_accept: got valid %0b expected 0", pulse_valid); end
  endtask

  task automatic test_glitch();
    logic [TS_W-1:0] ts_exp;
    int tog;
    step(5);
    drive_pulse(3, 1, ts_exp, tog);
    step(10);
    checks++; if (pulse_valid !== 1'b0) begin errors++; $display("FAIL glitch_valid: got %0b expected 0", pulse_valid); end
    checks++; if (int'(drop_count) != exp_drop) begin errors++; $display("FAIL glitch_drop: got %0d expected %0d", drop_count, exp_drop); end
  endtask

  task automatic test_backpressure();
    logic [TS_W-1:0] ts_first;
    logic [TS_W-1:0] ts_tmp;
    int tog_first;
    int tog_tmp;
    pulse_ready = 1'b0;
    drive_pulse(20, $urandom_range(0, 10), ts_first, tog_first);
    step(5);
    drive_pulse(20, $urandom_range(0, 10), ts_tmp, tog_tmp);
    step(5);
    drive_pulse(20, $urandom_range(0, 10), ts_tmp, tog_tmp);
    step(6);
    exp_drop += 2;
    checks++; if (pulse_valid !== 1'b1) begin errors++; $display("FAIL bp_valid: got %0b expected 1", pulse_valid); end
    checks++; if (pulse_ts !== ts_first) begin errors++; $display("FAIL bp_ts: got %0d expected %0d", pulse_ts, ts_first); end
    checks++; if (int'(pulse_width) < 19 || int'(pulse_width) > 21) begin errors++; $display("FAIL bp_width: got %0d expected 20+-1", pulse_width); end
    checks++; if (int'(pulse_d_edges) != tog_first) begin errors++; $display("FAIL bp_dedges: got %0d expected %0d", pulse_d_edges, tog_first); end
    checks++; if (int'(drop_count) != exp_drop) begin errors++; $display("FAIL bp_drop: got %0d expected %0d", drop_count, exp_drop); end
    pulse_ready = 1'b1;
    step(1);
    pulse_ready = 1'b0;
    checks++; if (pulse_valid !== 1'b0) begin errors++; $display("FAIL bp_accept: got valid %0b expected 0", pulse_valid); end
  endtask

  task automatic test_back_to_back();
    logic [TS_W-1:0] ts_a;
    logic [TS_W-1:0] ts_b;
    int tog_a;
    int tog_b;
    int waited;
    bit ok;
    pulse_ready = 1'b0;
    step(3);
    drive_pulse(12, 2, ts_a, tog_a);
    wait_valid(10, waited, ok);
    checks++; if (!ok || pulse_ts !== ts_a) begin errors++; $display("FAIL sim_first: got valid %0b ts %0d expected valid 1 ts %0d", ok, pulse_ts, ts_a); end
    step(2);
    drive_pulse(15, 4, ts_b, tog_b);
    step(2);
    pulse_ready = 1'b1;
    step(1);
    checks++; if (pulse_valid !== 1'b1) begin errors++; $display("FAIL sim_valid: got %0b expected 1", pulse_valid); end
    checks++; if (pulse_ts !== ts_b || int'(pulse_d_edges) != tog_b) begin errors++; $display("FAIL sim_record: got ts %0d edges %0d expected ts %0d edges %0d", pulse_ts, pulse_d_edges, ts_b, tog_b); end
    checks++; if (int'(drop_count) != exp_drop) begin errors++; $display("FAIL sim_drop: got %0d expected %0d", drop_count, exp_drop); end
    step(1);
    pulse_ready = 1'b0;
    checks++; if (pulse_valid !== 1'b0) begin errors++; $display("FAIL sim_drain: got valid %0b expected 0", pulse_valid); end
  endtask

  task automatic test_partial_disable();
    logic [TS_W-1:0] ts_exp;
    int tog;
    int waited;
    bit ok;
    pulse_ready = 1'b0;
    configured = 1'b0;
    e_in = 1'b0;
    step(5);
    configured = 1'b1;
    step(10);
    e_in = 1'b1;
    step(8);
    checks++; if (pulse_valid !== 1'b0) begin errors++; $display("FAIL partial_nocap: got valid %0b expected 0", pulse_valid); end
    drive_pulse(30, 2, ts_exp, tog);
    wait_valid(10, waited, ok);
    checks++; if (!ok || pulse_ts !== ts_exp) begin errors++; $display("FAIL partial_fresh: got valid %0b ts %0d expected valid 1 ts %0d", ok, pulse_ts, ts_exp); end
    checks++; if (int'(pulse_width) < 29 || int'(pulse_width) > 31 || int'(pulse_d_edges) != tog) begin errors++; $display("FAIL partial_fields: got width %0d edges %0d expected 30+-1 and %0d", pulse_width, pulse_d_edges, tog); end
    pulse_ready = 1'b1;
    step(1);
    pulse_ready = 1'b0;
    e_in = 1'b0;
    step(20);
    configured = 1'b0;
    step(3);
    e_in = 1'b1;
    step(5);
    configured = 1'b1;
    step(10);
    checks++; if (pulse_valid !== 1'b0) begin errors++; $display("FAIL disable_abort: got valid %0b expected 0", pulse_valid); end
    checks++; if (int'(drop_count) != exp_drop) begin errors++; $display("FAIL disable_drop: got %0d expected %0d", drop_count, exp_drop); end
  endtask

  task automatic test_random();
    logic [TS_W-1:0] ts_exp;
    int low;
    int tog;
    int n;
    pulse_ready = 1'b1;
    step(5);
    got_q.delete();
    exp_q.delete();
    for (int p = 0; p < 40; p++) begin
      low = $urandom_range(1, 40);
      drive_pulse(low, $urandom_range(0, 8), ts_exp, tog);
      if (low >= MIN_W) exp_q.push_back('{ts: ts_exp, width: low, dedges: tog});
      step($urandom_range(1, 6));
    end
    step(10);
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_count: got %0d records expected %0d", got_q.size(), exp_q.size()); end
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (got_q[i].ts !== exp_q[i].ts || got_q[i].dedges != exp_q[i].dedges ||
          got_q[i].width < exp_q[i].width - 1 || got_q[i].width > exp_q[i].width + 1) begin
        errors++;
        $display("FAIL rand_rec%0d: got ts %0d w %0d e %0d expected ts %0d w %0d e %0d", i,
                 got_q[i].ts, got_q[i].width, got_q[i].dedges, exp_q[i].ts, exp_q[i].width, exp_q[i].dedges);
      end
    end
    checks++; if (int'(drop_count) != exp_drop) begin errors++; $display("FAIL rand_drop: got %0d expected %0d", drop_count, exp_drop); end
    pulse_ready = 1'b0;
  endtask

  task automatic test_wrap();
    logic [TS_W-1:0] ts_exp;
    int tog;
    int waited;
    bit ok;
    bit hit = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      if (model_ts == 12'd4094) begin
        hit = 1'b1;
        break;
      end
      step(1);
    end
    checks++; if (!hit) begin errors++; $display("FAIL wrap_reach: got no timestamp 4094 expected within 5000 cycles"); end
    drive_pulse(10, 1, ts_exp, tog);
    wait_valid(10, waited, ok);
    checks++; if (!ok || pulse_ts !== ts_exp || ts_exp !== 12'd0) begin errors++; $display("FAIL wrap_ts: got valid %0b ts %0d expected valid 1 ts 0", ok, pulse_ts); end
    pulse_ready = 1'b1;
    step(1);
    pulse_ready = 1'b0;
  endtask

  task automatic test_saturation();
    logic [TS_W-1:0] ts_exp;
    int tog;
    int waited;
    bit ok;
    step(4);
    drive_pulse(70000, 0, ts_exp, tog);
    wait_valid(10, waited, ok);
    checks++; if (!ok || pulse_width !== 16'hFFFF) begin errors++; $display("FAIL sat_width: got valid %0b width %0h expected valid 1 width ffff", ok, pulse_width); end
    checks++; if (pulse_d_edges !== 8'd0 || pulse_ts !== ts_exp) begin errors++; $display("FAIL sat_fields: got edges %0d ts %0d expected 0 and %0d", pulse_d_edges, pulse_ts, ts_exp); end
  endtask

  task automatic test_reset_mid_pulse();
    checks++; if (int'(drop_count) != exp_drop || pulse_valid !== 1'b1) begin errors++; $display("FAIL prerst_state: got drop %0d valid %0b expected %0d and 1", drop_count, pulse_valid, exp_drop); end
    e_in = 1'b0;
    step(20);
    #3;
    rst = 1'b1;
    #1;
    test_reset();
    e_in = 1'b1;
    rst = 1'b0;
    step(5);
  endtask

  initial begin
    rst = 1'b1;
    configured = 1'b0;
    e_in = 1'b1;
    d_in = 1'b0;
    pulse_ready = 1'b0;
    #23;
    test_reset();
    rst = 1'b0;
    step(2);
    test_basic();
    test_glitch();
    test_backpressure();
    test_back_to_back();
    test_partial_disable();
    test_random();
    test_wrap();
    test_saturation();
    test_reset_mid_pulse();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
